// File: rtl/block_memory_reader.sv
// SSID lookup engine: checks the HNM hit bitmap, reads the HCM count and address, then streams HIM hit words oldest first.
// Optional READER_COUNTERS_EN adds saturating request and hit counters.
module block_memory_reader #(
   parameter int SSIDBITS          = 16,
   parameter int COLINDEXBITS_HNM  = 4,
   parameter int HITINFOBITS       = 8,
   parameter int ROWINDEXBITS_HIM  = 9,
   parameter int MAXHITNBITS       = 4,
   parameter int NCOLS_HIM         = 64,
   localparam int NCOLS_HNM        = 1 << COLINDEXBITS_HNM,
   localparam int ROWINDEXBITS_HNM = SSIDBITS - COLINDEXBITS_HNM,
   localparam int HCMBITS          = ROWINDEXBITS_HIM + MAXHITNBITS,
   localparam int MAXHITS          = NCOLS_HIM / HITINFOBITS,
   localparam int SLOTBITS         = (MAXHITS > 1) ? $clog2(MAXHITS) : 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        storageReady,
   input  logic                        requestValid,
   output logic                        requestReady,
   input  logic [SSIDBITS-1:0]         SSID,
   output logic [ROWINDEXBITS_HNM-1:0] rowIndex_HNM,
   input  logic [NCOLS_HNM-1:0]        dataOutput_HNM,
   output logic [SSIDBITS-1:0]         rowIndex_HCM,
   input  logic [HCMBITS-1:0]          dataOutput_HCM,
   output logic [ROWINDEXBITS_HIM-1:0] rowIndex_HIM,
   input  logic [NCOLS_HIM-1:0]        dataOutput_HIM,
   output logic                        hitValid,
   input  logic                        hitReady,
   output logic [HITINFOBITS-1:0]      hitInfo,
   output logic                        hitLast,
   output logic                        emptyValid,
   output logic                        overflow
`ifdef READER_COUNTERS_EN
   ,
   output logic [15:0]                 requestCount,
   output logic [15:0]                 hitsReadCount
`endif
);

   typedef enum logic [2:0] {IDLE, WAIT1, CHECK, WAIT2, LOAD, EMIT} state_t;

   state_t                      state;
   logic [MAXHITNBITS-1:0]      count_q;
   logic [SLOTBITS-1:0]         slot;
   logic [NCOLS_HIM-1:0]        hit_data;

   logic                        accept;
   logic                        hit_fire;
   logic                        hnm_hit;
   logic [MAXHITNBITS-1:0]      hcm_count;
   logic [ROWINDEXBITS_HIM-1:0] hcm_addr;
   logic                        count_over;
   logic [SLOTBITS-1:0]         start_slot;

   function automatic logic [HITINFOBITS-1:0] word_of(input logic [NCOLS_HIM-1:0] data,
                                                      input logic [SLOTBITS-1:0]  idx);
      return data[int'(idx)*HITINFOBITS +: HITINFOBITS];
   endfunction

   assign requestReady = (state == IDLE) && storageReady && !reset;
   assign accept       = requestValid && requestReady;
   assign hit_fire     = hitValid && hitReady;

   // The column of the request in flight is read back from the held HCM address,
   // so a changing SSID input cannot disturb it.
   assign hnm_hit   = dataOutput_HNM[rowIndex_HCM[COLINDEXBITS_HNM-1:0]];
   assign hcm_count = dataOutput_HCM[MAXHITNBITS-1:0];
   assign hcm_addr  = dataOutput_HCM[HCMBITS-1:MAXHITNBITS];

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      count_over = 1'b0;
      start_slot = '0;
      if (int'(hcm_count) > MAXHITS) count_over = 1'b1;
      if (int'(count_q) > MAXHITS) start_slot = SLOTBITS'(MAXHITS - 1);
      else                         start_slot = SLOTBITS'(int'(count_q) - 1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         rowIndex_HNM <= '0;
         rowIndex_HCM <= '0;
         rowIndex_HIM <= '0;
         count_q      <= '0;
         slot         <= '0;
         hit_data     <= '0;
         hitValid     <= 1'b0;
         hitInfo      <= '0;
         hitLast      <= 1'b0;
         emptyValid   <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         emptyValid <= 1'b0;
         overflow   <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  rowIndex_HNM <= SSID[SSIDBITS-1:COLINDEXBITS_HNM];
                  rowIndex_HCM <= SSID;
                  state        <= WAIT1;
               end
            end
            WAIT1: state <= CHECK;
            CHECK: begin
               if (!hnm_hit || hcm_count == '0) begin
                  emptyValid <= 1'b1;
                  state      <= IDLE;
               end else begin
                  count_q      <= hcm_count;
                  rowIndex_HIM <= hcm_addr;
                  overflow     <= count_over;
                  state        <= WAIT2;
               end
            end
            WAIT2: state <= LOAD;
            LOAD: begin
               hit_data <= dataOutput_HIM;
               slot     <= start_slot;
               hitInfo  <= word_of(dataOutput_HIM, start_slot);
               hitLast  <= (start_slot == '0);
               hitValid <= 1'b1;
               state    <= EMIT;
            end
            EMIT: begin
               if (hit_fire) begin
                  if (hitLast) begin
                     hitValid <= 1'b0;
                     hitLast  <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     slot    <= slot - 1'b1;
                     hitInfo <= word_of(hit_data, slot - 1'b1);
                     hitLast <= (slot == SLOTBITS'(1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef READER_COUNTERS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         requestCount  <= '0;
         hitsReadCount <= '0;
      end else begin
         if (accept && requestCount != 16'hFFFF)    requestCount  <= requestCount + 16'd1;
         if (hit_fire && hitsReadCount != 16'hFFFF) hitsReadCount <= hitsReadCount + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_block_memory_reader.sv
// Directed bench for block_memory_reader: bench-side HNM/HCM/HIM models and a queue of expected hit words.
module tb_block_memory_reader;

   logic        clock = 1'b0;
   logic        reset;
   logic        storageReady;
   logic        requestValid;
   logic        requestReady;
   logic [15:0] SSID;
   logic [11:0] rowIndex_HNM;
   logic [15:0] dataOutput_HNM;
   logic [15:0] rowIndex_HCM;
   logic [12:0] dataOutput_HCM;
   logic [8:0]  rowIndex_HIM;
   logic [63:0] dataOutput_HIM;
   logic        hitValid;
   logic        hitReady;
   logic [7:0]  hitInfo;
   logic        hitLast;
   logic        emptyValid;
   logic        overflow;
`ifdef READER_COUNTERS_EN
   logic [15:0] requestCount;
   logic [15:0] hitsReadCount;
`endif

   logic [15:0] hnm [0:4095];
   logic [12:0] hcm [0:65535];
   logic [63:0] him [0:511];
   logic [7:0]  exp_q [$];

   int n_assert = 0;
   int n_fail   = 0;

   block_memory_reader dut (
      .clock          (clock),
      .reset          (reset),
      .storageReady   (storageReady),
      .requestValid   (requestValid),
      .requestReady   (requestReady),
      .SSID           (SSID),
      .rowIndex_HNM   (rowIndex_HNM),
      .dataOutput_HNM (dataOutput_HNM),
      .rowIndex_HCM   (rowIndex_HCM),
      .dataOutput_HCM (dataOutput_HCM),
      .rowIndex_HIM   (rowIndex_HIM),
      .dataOutput_HIM (dataOutput_HIM),
      .hitValid       (hitValid),
      .hitReady       (hitReady),
      .hitInfo        (hitInfo),
      .hitLast        (hitLast),
      .emptyValid     (emptyValid),
      .overflow       (overflow)
`ifdef READER_COUNTERS_EN
      ,
      .requestCount   (requestCount),
      .hitsReadCount  (hitsReadCount)
`endif
   );

   always #5 clock = ~clock;

   // Block RAMs with one cycle of read latency.
   always @(posedge clock) begin
      dataOutput_HNM <= hnm[rowIndex_HNM];
      dataOutput_HCM <= hcm[rowIndex_HCM];
      dataOutput_HIM <= him[rowIndex_HIM];
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clock);
   endtask

   task automatic start_req(input logic [15:0] ssid);
      SSID         = ssid;
      requestValid = 1'b1;
      check("req_ready", requestReady, 1);
   endtask

   task automatic expect_empty(input logic [15:0] ssid);
      start_req(ssid);
      tick;
      requestValid = 1'b0;
      check("empty_busy", requestReady, 0);
      tick;
      check("empty_c2", emptyValid, 0);
      tick;
      check("empty_pulse", emptyValid, 1);
      check("empty_no_hit", hitValid, 0);
      check("empty_no_ovf", overflow, 0);
      tick;
      check("empty_pulse_end", emptyValid, 0);
      check("empty_idle", requestReady, 1);
   endtask

   // Walks cycles 1..5 after the request is accepted; hold_req keeps requestValid
   // high and changes SSID while busy.
   task automatic lead_in(input logic [15:0] ssid, input logic [8:0] him_addr,
                          input logic exp_ovf, input bit hold_req);
      logic [11:0] row;
      row = ssid[15:4];
      tick;
      if (hold_req) SSID = 16'h0456;
      else requestValid = 1'b0;
      check("lead_busy", requestReady, 0);
      check("lead_hnm_addr", rowIndex_HNM, row);
      check("lead_hcm_addr", rowIndex_HCM, ssid);
      tick;
      check("lead_c2_valid", hitValid, 0);
      tick;
      check("lead_overflow", overflow, exp_ovf);
      check("lead_no_empty", emptyValid, 0);
      check("lead_him_addr", rowIndex_HIM, him_addr);
      check("lead_hnm_held", rowIndex_HNM, row);
      tick;
      check("lead_ovf_end", overflow, 0);
      check("lead_c4_valid", hitValid, 0);
      requestValid = 1'b0;
      tick;
      check("first_hit_c5", hitValid, 1);
   endtask

   task automatic drain(input int max_cycles, input logic [7:0] stall_word, input int stall_n);
      int   cyc;
      int   stall_done;
      bit   stalling;
      logic [7:0] exp_w;
      cyc        = 0;
      stall_done = 0;
      stalling   = 1'b0;
      while (exp_q.size() > 0 && cyc < max_cycles) begin
         if (stalling && stall_done < stall_n) begin
            check("bp_valid_held", hitValid, 1);
            check("bp_word_held", hitInfo, stall_word);
            hitReady = 1'b0;
            stall_done++;
         end else if (hitValid === 1'b1) begin
            if (stall_n > 0 && !stalling && stall_done == 0 && hitInfo === stall_word) begin
               stalling   = 1'b1;
               stall_done = 1;
               hitReady   = 1'b0;
            end else begin
               stalling = 1'b0;
               hitReady = 1'b1;
               exp_w    = exp_q.pop_front();
               check("hit_word", hitInfo, exp_w);
               check("hit_last", hitLast, (exp_q.size() == 0));
            end
         end
         tick;
         cyc++;
      end
      check("drain_left", exp_q.size(), 0);
      exp_q.delete();
      hitReady = 1'b1;
      check("drain_valid_low", hitValid, 0);
      check("drain_idle", requestReady, 1);
   endtask

   initial begin
      reset        = 1'b1;
      storageReady = 1'b1;
      requestValid = 1'b0;
      hitReady     = 1'b1;
      SSID         = '0;
      for (int i = 0; i < 4096; i++)  hnm[i] = '0;
      for (int i = 0; i < 65536; i++) hcm[i] = '0;
      for (int i = 0; i < 512; i++)   him[i] = '0;

      // Reset held for three cycles.
      repeat (3) tick;
      check("rst_hitValid", hitValid, 0);
      check("rst_hitLast", hitLast, 0);
      check("rst_hitInfo", hitInfo, 0);
      check("rst_empty", emptyValid, 0);
      check("rst_overflow", overflow, 0);
      check("rst_hnm_addr", rowIndex_HNM, 0);
      check("rst_hcm_addr", rowIndex_HCM, 0);
      check("rst_him_addr", rowIndex_HIM, 0);
      check("rst_ready", requestReady, 0);
      reset = 1'b0;
      tick;
      check("post_rst_ready", requestReady, 1);

      // No acceptance while the writer is busy.
      storageReady = 1'b0;
      requestValid = 1'b1;
      SSID         = 16'h0123;
      repeat (3) tick;
      check("stor_busy_ready", requestReady, 0);
      check("stor_busy_addr", rowIndex_HCM, 0);
      requestValid = 1'b0;
      storageReady = 1'b1;
      tick;

      // Empty: bitmap clear; bit set but zero count; neighbouring column set.
      hnm[12'h012] = 16'h0000;
      hcm[16'h0123] = {9'd5, 4'd3};
      expect_empty(16'h0123);
      hnm[12'h012] = 16'h0008;
      hcm[16'h0123] = {9'd5, 4'd0};
      expect_empty(16'h0123);
      hnm[12'h012] = 16'h0004;
      hcm[16'h0123] = {9'd5, 4'd3};
      expect_empty(16'h0123);

      // Three hits, with requestValid held and SSID changed while busy.
      hnm[12'h012] = 16'h0008;
      hcm[16'h0123] = {9'd5, 4'd3};
      him[5] = 64'h0102_0304_05AA_BBCC;
      exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
      start_req(16'h0123);
      lead_in(16'h0123, 9'd5, 1'b0, 1'b1);
      drain(40, 8'h00, 0);

      // Backpressure on 0xBB for two cycles.
      exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
      start_req(16'h0123);
      lead_in(16'h0123, 9'd5, 1'b0, 1'b0);
      drain(40, 8'hBB, 2);

      // Count 12: overflow pulse and only eight words.
      hnm[12'h023] = 16'h0070;
      hcm[16'h0234] = {9'd7, 4'd12};
      him[7] = 64'h1122_3344_5566_7788;
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
      exp_q.push_back(8'h55); exp_q.push_back(8'h66); exp_q.push_back(8'h77); exp_q.push_back(8'h88);
      start_req(16'h0234);
      lead_in(16'h0234, 9'd7, 1'b1, 1'b0);
      drain(60, 8'h00, 0);

      // Count exactly 8: full row, no overflow.
      hcm[16'h0235] = {9'd8, 4'd8};
      him[8] = 64'hF0E1_D2C3_B4A5_9687;
      exp_q.push_back(8'hF0); exp_q.push_back(8'hE1); exp_q.push_back(8'hD2); exp_q.push_back(8'hC3);
      exp_q.push_back(8'hB4); exp_q.push_back(8'hA5); exp_q.push_back(8'h96); exp_q.push_back(8'h87);
      start_req(16'h0235);
      lead_in(16'h0235, 9'd8, 1'b0, 1'b0);
      drain(60, 8'h00, 0);

      // Count 1: the first word is also the last.
      hcm[16'h0236] = {9'd9, 4'd1};
      him[9] = 64'h0000_0000_0000_7E5A;
      exp_q.push_back(8'h5A);
      start_req(16'h0236);
      lead_in(16'h0236, 9'd9, 1'b0, 1'b0);
      drain(20, 8'h00, 0);

      // Reset in the middle of EMIT.
      start_req(16'h0123);
      lead_in(16'h0123, 9'd5, 1'b0, 1'b0);
      hitReady = 1'b0;
      reset    = 1'b1;
      tick;
      check("mid_rst_valid", hitValid, 0);
      check("mid_rst_last", hitLast, 0);
      check("mid_rst_info", hitInfo, 0);
      check("mid_rst_him_addr", rowIndex_HIM, 0);
      check("mid_rst_hnm_addr", rowIndex_HNM, 0);
      reset = 1'b0;
      tick;
      check("mid_rst_idle", requestReady, 1);
      check("mid_rst_valid2", hitValid, 0);
      hitReady = 1'b1;

      // Three-hit sequence again after reset, with counters observed.
      exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
      start_req(16'h0123);
      lead_in(16'h0123, 9'd5, 1'b0, 1'b0);
      drain(40, 8'h00, 0);
`ifdef READER_COUNTERS_EN
      check("cnt_requests", requestCount, 16'd1);
      check("cnt_hits", hitsReadCount, 16'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/block_memory_reader.md
BLOCK_MEMORY_READER -- requirements
Module: block_memory_reader

Interface
REQ-001 SHALL take parameter SSIDBITS, default 16: SSID width; row = SSID[15:4], col = SSID[3:0].
REQ-002 SHALL take parameter COLINDEXBITS_HNM, default 4: column bits per HNM row; NCOLS_HNM = 16.
REQ-003 SHALL take parameter HITINFOBITS, default 8: width of one hit-info word.
REQ-004 SHALL take parameter ROWINDEXBITS_HIM, default 9: HIM address width.
REQ-005 SHALL take parameter MAXHITNBITS, default 4: HCM count field width; MAXHITS = NCOLS_HIM/HITINFOBITS = 8 (NCOLS_HIM default 64).
REQ-006 SHALL have the following ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- storageReady  in  1  writer idle; requests accepted only while high.
- requestValid  in  1  SSID lookup request.
- requestReady  out  1  high only in IDLE with storageReady=1.
- SSID  in  SSIDBITS  SSID to read.
- rowIndex_HNM  out  12  HNM port A read address.
- dataOutput_HNM  in  16  HNM port A data, 1-cycle latency.
- rowIndex_HCM  out  SSIDBITS  HCM read address.
- dataOutput_HCM  in  13  HCM data: [12:4] HIM address, [3:0] count.
- rowIndex_HIM  out  9  HIM read address.
- dataOutput_HIM  in  64  HIM data.
- hitValid  out  1  hitInfo valid.
- hitReady  in  1  consumer accepts hitInfo.
- hitInfo  out  HITINFOBITS  one hit word.
- hitLast  out  1  final word of this SSID.
- emptyValid  out  1  one-cycle pulse: SSID has no hits.
- overflow  out  1  one-cycle pulse: count exceeded MAXHITS.

Function
REQ-007 SHALL use FSM states IDLE, WAIT1, CHECK, WAIT2, LOAD, EMIT.
REQ-008 SHALL accept a request on a rising edge with requestValid && requestReady, latch SSID, drive rowIndex_HNM = row and rowIndex_HCM = SSID, and go to WAIT1.
REQ-009 SHALL go WAIT1 -> CHECK unconditionally, covering BRAM read latency.
REQ-010 SHALL, in CHECK, test bit dataOutput_HNM[col]; if 0 or count==0, pulse emptyValid and return to IDLE (3 cycles after acceptance).
REQ-011 SHALL, in CHECK with a hit, latch count and HIM address, drive rowIndex_HIM, and go to WAIT2, then LOAD; LOAD latches dataOutput_HIM and enters EMIT.
REQ-012 SHALL assert the first hitValid 5 cycles after acceptance.
REQ-013 SHALL emit hits oldest first: for count n, slots n-1 down to 0, where slot k = bits [8k+7:8k].
REQ-014 SHALL hold hitInfo/hitValid stable while hitReady=0 and advance only on hitValid && hitReady.
REQ-015 SHALL assert hitLast with the slot-0 word and return to IDLE on its handshake.
REQ-016 SHALL, if count > MAXHITS, emit MAXHITS words (slots 7..0) and pulse overflow in CHECK.
REQ-017 SHALL ignore requestValid outside IDLE; an SSID change while busy SHALL NOT affect the read in flight.
REQ-018 SHALL hold memory addresses at their last value when idle and never write any memory.

Reset
REQ-019 SHALL, on reset (including mid-operation), go to IDLE and zero hitValid, hitLast, hitInfo, emptyValid, overflow, addresses and latched count.
REQ-020 SHALL make requestReady = storageReady in the first cycle after reset deasserts.

Configuration
REQ-021 SHALL support macro READER_COUNTERS_EN: when defined, add 16-bit outputs requestCount (incremented per accepted request) and hitsReadCount (incremented per hit handshake), both saturating at 0xFFFF and cleared by reset; when undefined, those ports and counters SHALL be absent.

Verification
REQ-022 SHALL verify reset: reset high 3 cycles -> all outputs 0; requestReady=1 the next cycle with storageReady=1.
REQ-023 SHALL verify an empty SSID: HNM[0x012]=0x0000, request SSID 0x0123 -> emptyValid pulse 3 cycles later, no hitValid.
REQ-024 SHALL verify three hits: HNM[0x012]=0x0008, HCM[0x0123]={9'd5,4'd3}, HIM[5]=0x...AABBCC -> 0xAA, 0xBB, 0xCC in order, first at +5 cycles, hitLast only on 0xCC.
REQ-025 SHALL verify backpressure: hitReady low 2 cycles on 0xBB -> 0xBB held stable, no word lost or duplicated.
REQ-026 SHALL verify overflow and reset: count=12 -> overflow pulse and exactly 8 words; separately, reset asserted during EMIT -> hitValid=0 next cycle, FSM in IDLE.
REQ-027 SHALL verify counters with READER_COUNTERS_EN: the REQ-024 sequence -> requestCount=1, hitsReadCount=3.
